// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op-group predicates for alu_md
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_SUB    = 5'b00011,
        OP_SRL    = 5'b00100,
        OP_SRA    = 5'b00101,
        OP_SLL    = 5'b00110,
        OP_XOR    = 5'b00111,
        OP_EQ     = 5'b01000,
        OP_SLT    = 5'b01001,
        OP_SLTU   = 5'b01010,
        OP_NE     = 5'b01011,
        OP_GE     = 5'b01100,
        OP_GEU    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_e;

    function automatic logic is_mul(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - radix-2 iterative multiplier / restoring divider
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         start,
    input  alu_op_e      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    logic           active;
    logic [CW-1:0]  count;
    logic           is_mul_q, sel_alt_q, neg_q, rneg_q, dz_q;
    logic [W-1:0]   a_q;
    logic [2*W-1:0] prod, mcand;
    logic [W-1:0]   mplier, quo, rem, divisor;

    logic           signed_a, signed_b, sa, sb;
    logic [W-1:0]   mag_a, mag_b;

    // Operands are reduced to magnitudes up front; signs are reapplied at the end.
    assign signed_a = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign signed_b = op inside {OP_MULH, OP_DIV, OP_REM};
    assign sa       = signed_a & a[W-1];
    assign sb       = signed_b & b[W-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;

    logic [2*W-1:0] prod_n, prod_f;
    logic [W:0]     r_sh;
    logic           fits;
    logic [W-1:0]   quo_n, rem_n, quo_f, rem_f;

    assign prod_n = prod + (mplier[0] ? mcand : '0);
    assign r_sh   = {rem, quo[W-1]};
    assign fits   = r_sh >= {1'b0, divisor};
    assign rem_n  = fits ? W'(r_sh - {1'b0, divisor}) : r_sh[W-1:0];
    assign quo_n  = {quo[W-2:0], fits};

    // Result is taken from the final step's next-values so it can be registered on done.
    assign prod_f = neg_q ? -prod_n : prod_n;
    assign quo_f  = dz_q ? '1  : (neg_q  ? -quo_n : quo_n);
    assign rem_f  = dz_q ? a_q : (rneg_q ? -rem_n : rem_n);

    assign done   = active && (count == '0);
    assign result = is_mul_q ? (sel_alt_q ? W'(prod_f >> W) : prod_n[W-1:0])
                             : (sel_alt_q ? rem_f : quo_f);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            count     <= '0;
            is_mul_q  <= 1'b0;
            sel_alt_q <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
        end else if (flush) begin
            active <= 1'b0;
            count  <= '0;
        end else if (start) begin
            active    <= 1'b1;
            count     <= CW'(W - 1);
            is_mul_q  <= is_mul(op);
            sel_alt_q <= op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            neg_q     <= sa ^ sb;
            rneg_q    <= sa;
            dz_q      <= (b == '0);
            a_q       <= a;
            prod      <= '0;
            mcand     <= {{W{1'b0}}, mag_a};
            mplier    <= mag_b;
            quo       <= mag_a;
            rem       <= '0;
            divisor   <= mag_b;
        end else if (active) begin
            prod   <= prod_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            quo    <= quo_n;
            rem    <= rem_n;
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - multi-cycle execute-stage ALU with valid/ready handshake and RV32M
module alu_md
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONE = 1;

    alu_op_e         op;
    alu_state_e      state, state_next, target;
    logic            accept, start, eng_done;
    logic [SHW-1:0]  shamt;
    logic [DATA_WIDTH-1:0] single_result, eng_result;

    assign op        = alu_op_e'(Operation);
    assign shamt     = SrcB[SHW-1:0];
    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign start     = accept && (is_mul(op) || is_div(op));
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == DIV);
    assign target    = is_mul(op) ? MUL : (is_div(op) ? DIV : DONE);

    always_comb begin
        single_result = '0;
        case (op)
            OP_AND:  single_result = SrcA & SrcB;
            OP_OR:   single_result = SrcA | SrcB;
            OP_ADD:  single_result = SrcA + SrcB;
            OP_SUB:  single_result = SrcA - SrcB;
            OP_SRL:  single_result = SrcA >> shamt;
            OP_SRA:  single_result = $signed(SrcA) >>> shamt;
            OP_SLL:  single_result = SrcA << shamt;
            OP_XOR:  single_result = SrcA ^ SrcB;
            OP_EQ:   single_result = (SrcA == SrcB) ? ONE : '0;
            OP_SLT:  single_result = ($signed(SrcA) < $signed(SrcB)) ? ONE : '0;
            OP_SLTU: single_result = (SrcA < SrcB) ? ONE : '0;
            OP_NE:   single_result = (SrcA != SrcB) ? ONE : '0;
            OP_GE:   single_result = ($signed(SrcA) >= $signed(SrcB)) ? ONE : '0;
            OP_GEU:  single_result = (SrcA >= SrcB) ? ONE : '0;
            default: single_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept) state_next = target;
                MUL, DIV: if (eng_done) state_next = DONE;
                DONE:     if (out_ready) state_next = accept ? target : IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ALUResult <= '0;
        end else begin
            state <= state_next;
            if (accept && !start) begin
                ALUResult <= single_result;
            end else if (eng_done && !flush) begin
                ALUResult <= eng_result;
            end
        end
    end

    alu_muldiv_iter #(.W(DATA_WIDTH)) u_iter (
        .clk    (clk),
        .rst    (reset),
        .flush  (flush),
        .start  (start),
        .op     (op),
        .a      (SrcA),
        .b      (SrcB),
        .done   (eng_done),
        .result (eng_result)
    );

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - self-checking bench for alu_md against an arithmetic reference model
module tb_alu_md;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [4:0]  Operation;
    logic [31:0] SrcA, SrcB, ALUResult;

    int checks = 0;
    int errors = 0;

    alu_md dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'b00000: return a & b;
            5'b00001: return a | b;
            5'b00010: return a + b;
            5'b00011: return a - b;
            5'b00100: return a >> b[4:0];
            5'b00101: return $signed(a) >>> b[4:0];
            5'b00110: return a << b[4:0];
            5'b00111: return a ^ b;
            5'b01000: return (a == b) ? 32'd1 : 32'd0;
            5'b01001: return (sa < sb) ? 32'd1 : 32'd0;
            5'b01010: return (a < b) ? 32'd1 : 32'd0;
            5'b01011: return (a != b) ? 32'd1 : 32'd0;
            5'b01100: return (sa >= sb) ? 32'd1 : 32'd0;
            5'b01101: return (a >= b) ? 32'd1 : 32'd0;
            5'b10000: begin p = sa * sb; return p[31:0]; end
            5'b10001: begin p = sa * sb; return p[63:32]; end
            5'b10010: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            5'b10011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            5'b10100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            5'b10101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'b10110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            5'b10111: return (b == 0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    // Reference of one in-flight op: remaining cycles until its result must be visible.
    logic        pend = 1'b0, exp_v, exp_ir, first_seen = 1'b0;
    int          rem_cnt = 0, cyc = 0, acc_cyc = 0, first_lat = 0;
    logic [31:0] exp_res = '0;
    logic [31:0] seen_q[$];
    int          lat_q[$];
    int          acc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pend = 1'b0;
            chk("reset out_valid", {31'd0, out_valid}, 32'd0);
            chk("reset busy", {31'd0, busy}, 32'd0);
            chk("reset ALUResult", ALUResult, 32'd0);
            chk("reset in_ready", {31'd0, in_ready}, {31'd0, !flush});
        end else begin
            if (pend && rem_cnt > 0) rem_cnt--;
            exp_v  = pend && rem_cnt == 0;
            exp_ir = !flush && (!pend || (exp_v && out_ready));
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            chk("busy", {31'd0, busy}, {31'd0, pend && rem_cnt > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            if (exp_v) chk("ALUResult", ALUResult, exp_res);
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                first_lat  = cyc - acc_cyc;
            end
            if (flush) begin
                pend = 1'b0;
            end else begin
                if (exp_v && out_ready) begin
                    pend = 1'b0;
                    seen_q.push_back(ALUResult);
                    lat_q.push_back(first_lat);
                end
                if (in_valid && exp_ir) begin
                    pend       = 1'b1;
                    exp_res    = model(Operation, SrcA, SrcB);
                    rem_cnt    = (Operation[4:3] == 2'b10) ? 33 : 1;
                    acc_cyc    = cyc;
                    first_seen = 1'b0;
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send: op %b not accepted within 200 cycles", op);
        in_valid = 1'b0;
    endtask

    task automatic got_next(input string name, input logic [31:0] exp, input int lat);
        int n = 0;
        while (seen_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (seen_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no result within 200 cycles", name);
        end else begin
            chk(name, seen_q.pop_front(), exp);
            chk({name, " latency"}, lat_q.pop_front(), lat);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        vq.push_back('{op, a, b, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Operation = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        sync();

        add(5'b00011, 32'd3, 32'd5, 32'hFFFF_FFFE);
        add(5'b00101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        add(5'b01010, 32'd1, 32'hFFFF_FFFF, 32'd1);
        add(5'b00000, 32'hF0, 32'h3C, 32'h30);
        add(5'b00001, 32'hF0, 32'h0F, 32'hFF);
        add(5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd0);
        add(5'b00100, 32'h8000_0000, 32'd31, 32'd1);
        add(5'b00110, 32'd1, 32'h21, 32'd2);
        add(5'b00111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        add(5'b01000, 32'd5, 32'd5, 32'd1);
        add(5'b01001, 32'hFFFF_FFFF, 32'd0, 32'd1);
        add(5'b01011, 32'd5, 32'd5, 32'd0);
        add(5'b01100, 32'h8000_0000, 32'd0, 32'd0);
        add(5'b01101, 32'h8000_0000, 32'd0, 32'd1);
        add(5'b01110, 32'd5, 32'd6, 32'd0);
        add(5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        add(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add(5'b10000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        add(5'b10010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        add(5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        add(5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        add(5'b10101, 32'd10, 32'd0, 32'hFFFF_FFFF);
        add(5'b10111, 32'd10, 32'd0, 32'd10);
        add(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        add(5'b10100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        add(5'b10110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        foreach (vq[i]) chk($sformatf("model vec%0d", i), model(vq[i].op, vq[i].a, vq[i].b), vq[i].exp);
        foreach (vq[i]) send(vq[i].op, vq[i].a, vq[i].b);
        foreach (vq[i]) got_next($sformatf("vec%0d op %b", i, vq[i].op), vq[i].exp, (vq[i].op[4:3] == 2'b10) ? 33 : 1);
        if (acc_q.size() >= 3) begin
            chk("b2b accept gap 1", acc_q[1] - acc_q[0], 32'd1);
            chk("b2b accept gap 2", acc_q[2] - acc_q[1], 32'd1);
        end else begin
            chk("b2b accept count", acc_q.size(), 32'd3);
        end

        // Backpressure on a completed MUL.
        sync();
        out_ready = 1'b0;
        send(5'b10000, 32'd6, 32'd7);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("bp valid reached", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp ALUResult held", ALUResult, 32'd42);
            chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        sync();
        out_ready = 1'b1;
        got_next("bp MUL", 32'd42, 33);

        // Reset in the middle of a DIV.
        sync();
        send(5'b10100, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset ALUResult", ALUResult, 32'd0);
        chk("async reset in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        sync();
        send(5'b00010, 32'd5, 32'd7);
        got_next("post-reset ADD", 32'd12, 1);

        // Flush in the middle of a DIV.
        sync();
        send(5'b10100, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        sync();
        send(5'b00000, 32'hF0, 32'h3C);
        got_next("post-flush AND", 32'h30, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
